// File: rtl/sram_ctrl_pkg.sv
// Shared types and default geometry for the burst SRAM controller.
// The default geometry matches the team's 16x8 synchronous-read SRAM.
package sram_ctrl_pkg;

    localparam int SRAM_ADDR_W = 4;
    localparam int SRAM_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        WR,
        RD
    } state_t;

endpackage

// File: rtl/sram_burst_ctrl.sv
// Burst controller for a single-port synchronous-read SRAM: streams write beats in,
// streams read beats out with valid/ready, and hides the SRAM's one-cycle read latency.
module sram_burst_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int ADDR_W = SRAM_ADDR_W,
    parameter int DATA_W = SRAM_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [ADDR_W-1:0] req_len,

    input  logic              wdata_valid,
    output logic              wdata_ready,
    input  logic [DATA_W-1:0] wdata,

    output logic              rdata_valid,
    input  logic              rdata_ready,
    output logic [DATA_W-1:0] rdata,
    output logic              rdata_last,

    output logic              done,

    output logic              mem_write_en,
    output logic              mem_read_en,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_data_in,
    input  logic [DATA_W-1:0] mem_data_out
);

    state_t            state;
    logic [ADDR_W-1:0] cur_addr;
    logic [ADDR_W-1:0] beats_left;   // beats still to hand over, minus one
    logic [ADDR_W:0]   issue_left;   // SRAM reads not yet issued (0..16)
    logic              rdata_valid_q;
    logic              done_q;

    logic              wr_hs;
    logic              rd_hs;
    logic              issue;

    assign wr_hs = rst_n && (state == WR) && wdata_valid;
    assign rd_hs = rdata_valid_q && rdata_ready;

    // A new read may only be issued when the output slot is empty or being emptied,
    // because the SRAM overwrites data_out on every read strobe.
    assign issue = rst_n && (state == RD) && (issue_left != '0)
                   && (!rdata_valid_q || rdata_ready);

    assign req_ready    = rst_n && (state == IDLE);
    assign wdata_ready  = rst_n && (state == WR);
    assign mem_write_en = wr_hs;
    assign mem_read_en  = issue;
    assign mem_address  = cur_addr;
    assign mem_data_in  = wdata;

    assign rdata_valid  = rdata_valid_q;
    assign rdata        = mem_data_out;
    assign rdata_last   = rdata_valid_q && (beats_left == '0);
    assign done         = done_q;

    // NOTE: all state updates use non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            cur_addr      <= '0;
            beats_left    <= '0;
            issue_left    <= '0;
            rdata_valid_q <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        cur_addr   <= req_addr;
                        beats_left <= req_len;
                        issue_left <= {1'b0, req_len} + (ADDR_W+1)'(1);
                        state      <= req_write ? WR : RD;
                    end
                end
                WR: begin
                    if (wr_hs) begin
                        cur_addr   <= cur_addr + ADDR_W'(1);
                        beats_left <= beats_left - ADDR_W'(1);
                        if (beats_left == '0) begin
                            state  <= IDLE;
                            done_q <= 1'b1;
                        end
                    end
                end
                RD: begin
                    if (issue) begin
                        cur_addr      <= cur_addr + ADDR_W'(1);
                        issue_left    <= issue_left - (ADDR_W+1)'(1);
                        rdata_valid_q <= 1'b1;
                    end else if (rd_hs) begin
                        rdata_valid_q <= 1'b0;
                    end
                    if (rd_hs) begin
                        beats_left <= beats_left - ADDR_W'(1);
                        if (beats_left == '0) begin
                            state  <= IDLE;
                            done_q <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_burst_ctrl.sv
// Directed bench for sram_burst_ctrl with a behavioural 16x8 synchronous-read SRAM
// attached; each task runs one scenario and checks outputs cycle by cycle.
module tb_sram_burst_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_valid, req_ready, req_write;
    logic [3:0] req_addr, req_len;
    logic       wdata_valid, wdata_ready;
    logic [7:0] wdata;
    logic       rdata_valid, rdata_ready, rdata_last;
    logic [7:0] rdata;
    logic       done;
    logic       mem_write_en, mem_read_en;
    logic [3:0] mem_address;
    logic [7:0] mem_data_in, mem_data_out;

    logic [7:0] sram [16];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    sram_burst_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_write   (req_write),
        .req_addr    (req_addr),
        .req_len     (req_len),
        .wdata_valid (wdata_valid),
        .wdata_ready (wdata_ready),
        .wdata       (wdata),
        .rdata_valid (rdata_valid),
        .rdata_ready (rdata_ready),
        .rdata       (rdata),
        .rdata_last  (rdata_last),
        .done        (done),
        .mem_write_en(mem_write_en),
        .mem_read_en (mem_read_en),
        .mem_address (mem_address),
        .mem_data_in (mem_data_in),
        .mem_data_out(mem_data_out)
    );

    // Behavioural SRAM: registered read, data_out held while read_en is low.
    always @(posedge clk) begin
        if (mem_write_en) sram[mem_address] <= mem_data_in;
        if (mem_read_en)  mem_data_out <= sram[mem_address];
    end

    task automatic test_reset();
        rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_len = '0;
        wdata_valid = 1'b0; wdata = '0; rdata_ready = 1'b0;
        @(negedge clk);
        n_tests++;
        if ({req_ready, wdata_ready, mem_write_en, mem_read_en} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_low_outputs: got %b expected 0000",
                     {req_ready, wdata_ready, mem_write_en, mem_read_en});
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        n_tests++;
        if ({req_ready, rdata_valid, done, mem_address} !== {3'b100, 4'd0}) begin
            n_fail++;
            $display("FAIL reset_state: got %b expected 1000000",
                     {req_ready, rdata_valid, done, mem_address});
        end
        @(posedge clk); #1;
    endtask

    task automatic write_burst(input logic [3:0] addr, input logic [3:0] len,
                               input logic [7:0] base, input logic [31:0] gap_mask,
                               input string name);
        int n, nb, cyc;
        logic hs;
        logic [3:0] ea;
        logic [7:0] ed;
        n = int'(len) + 1;
        req_valid = 1'b1; req_write = 1'b1; req_addr = addr; req_len = len; wdata_valid = 1'b0;
        @(negedge clk);
        n_tests++;
        if ({req_ready, wdata_ready} !== 2'b10) begin
            n_fail++;
            $display("FAIL %s_accept: req_ready/wdata_ready got %b expected 10", name, {req_ready, wdata_ready});
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        nb = 0; cyc = 0;
        while (nb < n && cyc < 64) begin
            wdata_valid = !gap_mask[cyc % 32];
            wdata = base + 8'(nb);
            @(negedge clk);
            n_tests++;
            if ({wdata_ready, mem_write_en, mem_read_en, done, rdata_valid} !== {1'b1, wdata_valid, 3'b000}) begin
                n_fail++;
                $display("FAIL %s_ctl cyc%0d: got %b expected %b", name, cyc,
                         {wdata_ready, mem_write_en, mem_read_en, done, rdata_valid}, {1'b1, wdata_valid, 3'b000});
            end
            if (wdata_valid) begin
                ea = addr + 4'(nb);
                ed = base + 8'(nb);
                n_tests++;
                if ({mem_address, mem_data_in} !== {ea, ed}) begin
                    n_fail++;
                    $display("FAIL %s_beat%0d: addr/data got %h/%h expected %h/%h", name, nb,
                             mem_address, mem_data_in, ea, ed);
                end
            end
            hs = wdata_valid;
            @(posedge clk); #1;
            if (hs) nb++;
            cyc++;
        end
        wdata_valid = 1'b0;
        n_tests++;
        if (nb != n) begin
            n_fail++;
            $display("FAIL %s_timeout: beats got %0d expected %0d", name, nb, n);
        end
        @(negedge clk);
        n_tests++;
        if ({done, req_ready, wdata_ready} !== 3'b110) begin
            n_fail++;
            $display("FAIL %s_done: done/req_ready/wdata_ready got %b expected 110", name, {done, req_ready, wdata_ready});
        end
        @(posedge clk); #1;
        @(negedge clk);
        n_tests++;
        if (done !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_done_pulse: done got %b expected 0", name, done);
        end
        for (int i = 0; i < n; i++) begin
            ea = addr + 4'(i);
            ed = base + 8'(i);
            n_tests++;
            if (sram[ea] !== ed) begin
                n_fail++;
                $display("FAIL %s_sram[%0d]: got %h expected %h", name, ea, sram[ea], ed);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic read_burst(input logic [3:0] addr, input logic [3:0] len,
                              input logic [7:0] base, input logic [31:0] ready_mask,
                              input bit check_time, input string name);
        int n, ni, nv, cyc;
        logic exp_valid, exp_issue, hs;
        logic [3:0] ea;
        logic [7:0] ed;
        n = int'(len) + 1;
        req_valid = 1'b1; req_write = 1'b0; req_addr = addr; req_len = len; rdata_ready = 1'b0;
        @(negedge clk);
        n_tests++;
        if (req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_accept: req_ready got %b expected 1", name, req_ready);
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        ni = 0; nv = 0; cyc = 0;
        while (nv < n && cyc < 64) begin
            rdata_ready = ready_mask[cyc % 32];
            @(negedge clk);
            exp_valid = (ni - nv) == 1;
            exp_issue = (ni < n) && (!exp_valid || rdata_ready);
            n_tests++;
            if ({rdata_valid, mem_read_en, mem_write_en, wdata_ready, done} !== {exp_valid, exp_issue, 3'b000}) begin
                n_fail++;
                $display("FAIL %s_ctl cyc%0d: got %b expected %b", name, cyc,
                         {rdata_valid, mem_read_en, mem_write_en, wdata_ready, done}, {exp_valid, exp_issue, 3'b000});
            end
            if (exp_issue) begin
                ea = addr + 4'(ni);
                n_tests++;
                if (mem_address !== ea) begin
                    n_fail++;
                    $display("FAIL %s_issue%0d: mem_address got %0d expected %0d", name, ni, mem_address, ea);
                end
            end
            if (exp_valid) begin
                ed = base + 8'(nv);
                n_tests++;
                if ({rdata, rdata_last} !== {ed, nv == n - 1}) begin
                    n_fail++;
                    $display("FAIL %s_beat%0d: rdata/last got %h/%b expected %h/%b", name, nv,
                             rdata, rdata_last, ed, nv == n - 1);
                end
            end
            hs = exp_valid && rdata_ready;
            @(posedge clk); #1;
            if (hs) nv++;
            if (exp_issue) ni++;
            cyc++;
        end
        rdata_ready = 1'b0;
        n_tests++;
        if (nv != n) begin
            n_fail++;
            $display("FAIL %s_timeout: beats got %0d expected %0d", name, nv, n);
        end
        if (check_time) begin
            n_tests++;
            if (cyc != n + 1) begin
                n_fail++;
                $display("FAIL %s_latency: cycles got %0d expected %0d", name, cyc, n + 1);
            end
        end
        @(negedge clk);
        n_tests++;
        if ({done, req_ready, rdata_valid} !== 3'b110) begin
            n_fail++;
            $display("FAIL %s_done: done/req_ready/rdata_valid got %b expected 110", name, {done, req_ready, rdata_valid});
        end
        @(posedge clk); #1;
        @(negedge clk);
        n_tests++;
        if (done !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_done_pulse: done got %b expected 0", name, done);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_write_read_basic();
        write_burst(4'd3, 4'd3, 8'hA1, 32'h0, "wr_basic");
        read_burst(4'd3, 4'd3, 8'hA1, 32'hFFFF_FFFF, 1'b1, "rd_basic");
    endtask

    task automatic test_wrap();
        write_burst(4'd14, 4'd3, 8'h10, 32'h0, "wr_wrap");
        read_burst(4'd14, 4'd3, 8'h10, 32'hFFFF_FFFF, 1'b1, "rd_wrap");
    endtask

    task automatic test_read_backpressure();
        // rdata_ready repeats 1,0,0
        read_burst(4'd3, 4'd3, 8'hA1, 32'h4924_9249, 1'b0, "rd_stall");
    endtask

    task automatic test_write_gaps();
        write_burst(4'd8, 4'd3, 8'h50, 32'b0110_0110, "wr_gaps");
        read_burst(4'd8, 4'd3, 8'h50, 32'hFFFF_FFFF, 1'b1, "rd_gaps");
    endtask

    task automatic test_reset_mid_read();
        write_burst(4'd0, 4'd7, 8'h30, 32'h0, "wr_eight");
        req_valid = 1'b1; req_write = 1'b0; req_addr = 4'd0; req_len = 4'd7;
        @(posedge clk); #1;
        req_valid = 1'b0; rdata_ready = 1'b1;
        @(negedge clk);
        n_tests++;
        if ({rdata_valid, mem_read_en} !== 2'b01) begin
            n_fail++;
            $display("FAIL rst_rd_entry: valid/read_en got %b expected 01", {rdata_valid, mem_read_en});
        end
        @(posedge clk); #1;
        @(negedge clk);
        n_tests++;
        if ({rdata_valid, rdata} !== {1'b1, 8'h30}) begin
            n_fail++;
            $display("FAIL rst_rd_beat1: valid/rdata got %b/%h expected 1/30", rdata_valid, rdata);
        end
        @(posedge clk); #1;
        @(negedge clk);
        n_tests++;
        if ({rdata_valid, rdata} !== {1'b1, 8'h31}) begin
            n_fail++;
            $display("FAIL rst_rd_beat2: valid/rdata got %b/%h expected 1/31", rdata_valid, rdata);
        end
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(negedge clk);
        n_tests++;
        if ({req_ready, mem_read_en, wdata_ready, mem_write_en} !== 4'b0000) begin
            n_fail++;
            $display("FAIL rst_rd_low: got %b expected 0000", {req_ready, mem_read_en, wdata_ready, mem_write_en});
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        n_tests++;
        if ({rdata_valid, req_ready, done, mem_address} !== {3'b010, 4'd0}) begin
            n_fail++;
            $display("FAIL rst_rd_after: valid/req_ready/done/addr got %b expected 0100000",
                     {rdata_valid, req_ready, done, mem_address});
        end
        @(posedge clk); #1;
        rdata_ready = 1'b0;
        @(negedge clk);
        n_tests++;
        if ({done, rdata_valid} !== 2'b00) begin
            n_fail++;
            $display("FAIL rst_rd_no_done: done/valid got %b expected 00", {done, rdata_valid});
        end
        @(posedge clk); #1;
        read_burst(4'd0, 4'd0, 8'h30, 32'hFFFF_FFFF, 1'b1, "rd_post_rst");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_write_read_basic();
        test_wrap();
        test_read_backpressure();
        test_write_gaps();
        test_reset_mid_read();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sram_burst_ctrl.md
# sram_burst_ctrl

Burst access controller driving the team's 16x8 single-port synchronous-read SRAM. Accepts one request at a time (write or read, 1–16 beats, incrementing address with wrap-around), streams write data into the SRAM and streams read data out with valid/ready flow control. It absorbs the SRAM's one-cycle read latency, so clients never handle SRAM timing directly.

## Interface
- ADDR_W, 4, SRAM address width (depth 2^ADDR_W)
- DATA_W, 8, SRAM word width
- clk  in  1  sole clock, rising edge
- rst_n  in  1  synchronous, active-low reset
- req_valid  in  1  request offered
- req_ready  out  1  controller idle, request accepted when both high
- req_write  in  1  1 = write burst, 0 = read burst
- req_addr  in  ADDR_W  start address
- req_len  in  ADDR_W  beats minus one (0 → 1 beat, 15 → 16 beats)
- wdata_valid  in  1  write beat offered
- wdata_ready  out  1  write beat accepted when both high
- wdata  in  DATA_W  write beat data
- rdata_valid  out  1  read beat present
- rdata_ready  in  1  consumer takes read beat
- rdata  out  DATA_W  read beat data
- rdata_last  out  1  marks final read beat
- done  out  1  one-cycle pulse after burst completes
- mem_write_en, mem_read_en  out  1  SRAM strobes
- mem_address  out  ADDR_W  SRAM address
- mem_data_in  out  DATA_W  SRAM write data
- mem_data_out  in  DATA_W  SRAM registered read data

## Operation
- States: IDLE, WR, RD. req_ready = (state == IDLE) && rst_n.
- IDLE: on req_valid handshake, latch addr into cur_addr, req_len into beats_left; go WR or RD per req_write.
- WR: wdata_ready = 1; mem_write_en = wdata_valid; mem_data_in = wdata; mem_address = cur_addr. Each handshake: cur_addr += 1 (mod 2^ADDR_W), beats_left −= 1. Handshake with beats_left == 0 → IDLE, done pulses next cycle.
- RD issue rule: mem_read_en = issue = (reads still to issue) && (!rdata_valid || rdata_ready). cur_addr increments per issue, wrapping 15 → 0.
- rdata is mem_data_out directly; rdata_valid is a register set on issue, cleared on handshake without a concurrent issue. The SRAM holds data_out while read_en is low, so a stalled beat stays stable.
- rdata_last = rdata_valid && the beat is the burst's final beat. Handshake on the last beat → IDLE, done pulses next cycle.
- The controller never asserts mem_write_en and mem_read_en together.
- wdata_ready = 0 outside WR. rdata_valid = 0 outside RD.
- Reset (rst_n low at edge): state IDLE, counters 0, rdata_valid 0, done 0, mem_address 0. All strobes and ready outputs are 0 while rst_n is low. Reset mid-burst abandons the burst with no done pulse; SRAM contents are untouched beyond beats already written.

## Timing
- Request accept → first write strobe: the next cycle, if wdata_valid is high.
- Read issue in cycle t → rdata_valid in cycle t+1. With rdata_ready held high, one beat per cycle; an N-beat read ends N+1 cycles after the RD entry cycle.
- done asserts exactly one cycle after the final beat handshake. req_ready is high in that same cycle (back-to-back requests allowed).
- A simultaneous rdata handshake and new issue keeps rdata_valid high, and the new data appears the next cycle.

## Structure
- Package sram_ctrl_pkg: state enum {IDLE, WR, RD}, default ADDR_W/DATA_W localparams.
- Single module, no sub-module; beat counter and address counter are inline. The testbench instantiates the SRAM alongside.

## Test plan
- Write addr 3, len 3, data 0xA1..0xA4 with continuous wdata_valid → SRAM[3..6] = A1..A4; done one cycle after the 4th beat.
- Read addr 3, len 3, rdata_ready = 1 → rdata A1, A2, A3, A4 on consecutive cycles; rdata_last only on A4; done next cycle.
- Write addr 14, len 3 (0x10..0x13), then read addr 14 len 3 → addresses 14, 15, 0, 1 in order; data 10..13 returned.
- Read 4 beats with rdata_ready toggling 1,0,0,1,… → no mem_read_en while stalled; rdata held stable; all 4 values correct, none duplicated.
- Write with wdata_valid gaps → mem_write_en only on valid cycles; SRAM content correct.
- rst_n low for one cycle mid-read (beat 2 of 8) → next cycle rdata_valid = 0, req_ready = 1, no done; subsequent 1-beat read at addr 0 returns correct data.
